// File: rtl/palette_loader.sv
// palette_loader: streams RGB888 colours into the palette BRAM as packed YCoCg-R words.
// Optional: define PALETTE_LOADER_CHECKSUM_EN to add a 16-bit running checksum of written words.
module palette_loader #(
    parameter int ADDRW = 9
) (
    input  logic             clk_draw,
    input  logic             rst_draw,
    input  logic             start,
    input  logic [ADDRW-1:0] base_addr,
    input  logic [ADDRW:0]   count,
    input  logic             in_valid,
    input  logic [23:0]      in_rgb,
    output logic             in_ready,
    output logic             busy,
    output logic             done,
    output logic             pal_we,
    output logic [ADDRW-1:0] pal_addr,
    output logic [23:0]      pal_data
`ifdef PALETTE_LOADER_CHECKSUM_EN
    ,
    output logic [15:0]      checksum
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DRAIN
    } state_t;

    state_t state;
    state_t state_next;
    logic   done_next;
    logic   start_ok;
    logic   accept;

    logic [ADDRW-1:0] addr;
    logic [ADDRW:0]   remaining;

    logic signed [7:0] r8;
    logic signed [7:0] g8;
    logic signed [7:0] b8;
    logic signed [7:0] co1;
    logic signed [7:0] tmp1;

    logic              s1_v;
    logic [ADDRW-1:0]  s1_addr;
    logic signed [7:0] s1_co;
    logic signed [7:0] s1_tmp;
    logic signed [7:0] s1_g;

    logic              s2_v;
    logic [ADDRW-1:0]  s2_addr;
    logic signed [7:0] s2_co;
    logic signed [7:0] s2_tmp;
    logic signed [7:0] s2_cg;

    logic              s3_v;
    logic [ADDRW-1:0]  s3_addr;
    logic signed [7:0] s3_co;
    logic signed [7:0] s3_cg;
    logic signed [7:0] s3_y;

    logic lsb_unused;

    // Colour LSBs are dropped; Y never exceeds 127 so its top bit is always zero
    assign lsb_unused = ^{in_rgb[16], in_rgb[8], in_rgb[0], s3_y[7]};

    assign r8   = {1'b0, in_rgb[23:17]};
    assign g8   = {1'b0, in_rgb[15:9]};
    assign b8   = {1'b0, in_rgb[7:1]};
    assign co1  = r8 - b8;
    assign tmp1 = b8 + (co1 >>> 1);

    always_ff @(posedge clk_draw or posedge rst_draw) begin
        if (rst_draw) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            done  <= done_next;
        end
    end

    always_comb begin
        state_next = state;
        done_next  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start_ok) begin
                    if (count == '0) begin
                        done_next = 1'b1;
                    end else begin
                        state_next = LOAD;
                    end
                end
            end
            LOAD: begin
                if (accept && remaining == (ADDRW+1)'(1)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (!(s1_v || s2_v || s3_v)) begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The done cycle still counts as busy so a start there is ignored
    always_comb begin
        in_ready = (state == LOAD);
        busy     = (state != IDLE) || done;
        start_ok = start && (state == IDLE) && !done;
        accept   = in_valid && in_ready;
    end

    always_ff @(posedge clk_draw or posedge rst_draw) begin
        if (rst_draw) begin
            addr      <= '0;
            remaining <= '0;
            s1_v      <= 1'b0;
            s1_addr   <= '0;
            s1_co     <= '0;
            s1_tmp    <= '0;
            s1_g      <= '0;
            s2_v      <= 1'b0;
            s2_addr   <= '0;
            s2_co     <= '0;
            s2_tmp    <= '0;
            s2_cg     <= '0;
            s3_v      <= 1'b0;
            s3_addr   <= '0;
            s3_co     <= '0;
            s3_cg     <= '0;
            s3_y      <= '0;
            pal_we    <= 1'b0;
            pal_addr  <= '0;
            pal_data  <= '0;
        end else begin
            if (start_ok) begin
                addr      <= base_addr;
                remaining <= count;
            end else if (accept) begin
                addr      <= addr + ADDRW'(1);
                remaining <= remaining - (ADDRW+1)'(1);
            end

            s1_v <= accept;
            if (accept) begin
                s1_addr <= addr;
                s1_co   <= co1;
                s1_tmp  <= tmp1;
                s1_g    <= g8;
            end

            s2_v <= s1_v;
            if (s1_v) begin
                s2_addr <= s1_addr;
                s2_co   <= s1_co;
                s2_tmp  <= s1_tmp;
                s2_cg   <= s1_g - s1_tmp;
            end

            s3_v <= s2_v;
            if (s2_v) begin
                s3_addr <= s2_addr;
                s3_co   <= s2_co;
                s3_cg   <= s2_cg;
                s3_y    <= s2_tmp + (s2_cg >>> 1);
            end

            pal_we <= s3_v;
            if (s3_v) begin
                pal_addr <= s3_addr;
                pal_data <= {1'b0, s3_y[6:0], s3_co, s3_cg};
            end
        end
    end

`ifdef PALETTE_LOADER_CHECKSUM_EN
    always_ff @(posedge clk_draw or posedge rst_draw) begin
        if (rst_draw) begin
            checksum <= '0;
        end else if (start_ok) begin
            checksum <= '0;
        end else if (pal_we) begin
            checksum <= checksum + 16'(pal_data[23:12]) + 16'(pal_data[11:0]);
        end
    end
`endif

endmodule

// File: doc/palette_loader.md
Name: palette_loader

Overview:
- Streams RGB888 colours into the palette BRAM, encoding each to the packed lossless YCoCg-R word the pixel pipeline's palette decoder expects.
- Lives in the draw clock domain. Driven by the host/command path.
- Emits a simple BRAM write port: write enable, address, data. That port feeds the palette BRAM's write side.
- Handles one burst per start: base address, entry count, valid/ready input stream, done pulse.

Parameters:
- ADDRW, 9, palette address width (512 entries, matches the 9-bit colour index).

Ports:
- clk_draw  in  1  draw clock
- rst_draw  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle pulse; begins a burst (ignored while busy)
- base_addr  in  ADDRW  first palette index, sampled on accepted start
- count  in  ADDRW+1  entries in burst, 0..2^ADDRW, sampled on accepted start
- in_valid  in  1  in_rgb holds a colour
- in_rgb  in  24  {R[7:0],G[7:0],B[7:0]}
- in_ready  out  1  loader accepts in_rgb this cycle
- busy  out  1  burst in progress
- done  out  1  one-cycle pulse after the last write of a burst
- pal_we  out  1  palette write enable
- pal_addr  out  ADDRW  palette write address
- pal_data  out  24  {1'b0, Y[6:0], Co[7:0], Cg[7:0]}

Behaviour:
- Reset values: in_ready=0, busy=0, done=0, pal_we=0, pal_addr=0, pal_data=0. Reset also sets state=IDLE, remaining=0, and clears all pipeline valid bits. Reset mid-burst discards in-flight entries; no write issues after reset asserts.
- FSM states: IDLE, LOAD, DRAIN.
  - IDLE: on start with count!=0, latch base_addr/count and go to LOAD. On start with count==0, pulse done the next cycle and stay in IDLE with no writes.
  - LOAD: in_ready=1. Each accept (in_valid&&in_ready) tags the entry with the current address, increments the address modulo 2^ADDRW (wraps 511->0), and decrements remaining. When the accept takes remaining to 0, go to DRAIN; in_ready is 0 from the next cycle.
  - DRAIN: in_ready=0. When no pipeline stage is valid, pulse done for one cycle, go to IDLE.
- busy=1 in LOAD and DRAIN, and through the done cycle. start while busy has no effect.
- Encode, on 7-bit inputs r=R[7:1], g=G[7:1], b=B[7:1] (signed 8-bit arithmetic, >>> is arithmetic shift):
  - S1 (accept cycle, registered): Co=r-b; tmp=b+(Co>>>1).
  - S2: Cg=g-tmp.
  - S3: Y=tmp+(Cg>>>1), truncated to 7 bits.
  - Output register: pal_we, pal_addr, pal_data.
- Encoding is exactly invertible by the decoder: tmp=Y-(Cg>>>1); G=Cg+tmp; B=tmp-(Co>>>1); R=B+Co.
- Latency: pal_we asserts 3 cycles after the accept edge. Writes leave in accept order, one per cycle max. Back-to-back accepts give back-to-back writes.
- No downstream backpressure: the BRAM always takes writes.
- in_valid outside LOAD is ignored.
- done is asserted the cycle after the final pal_we.

Optional Feature:
- Macro: PALETTE_LOADER_CHECKSUM_EN.
- Defined: adds output port checksum [15:0].
  - Cleared on accepted start.
  - On each pal_we, checksum <= checksum + pal_data[23:12] + pal_data[11:0], mod 2^16.
  - Valid and stable from the done pulse until the next accepted start. Reset value 0.
- Undefined: no port, no logic. All other behaviour is identical.

Test Plan:
- White burst: start base=0x010 count=1, in_rgb=0xFFFFFF -> one pal_we, addr 0x010, data 0x7F0000 three cycles after accept; done the next cycle.
- Red then blue, back-to-back, base=0x1FF count=2: 0xFF0000, 0x0000FF -> addr 0x1FF data 0x1F7FC1, then addr 0x000 data 0x1F81C1 (wrap); in_ready drops after the 2nd accept.
- Stalled stream: count=3 with in_valid gaps of 0/2/5 cycles -> exactly 3 writes at sequential addresses, in order; done only after the third write. A start pulsed mid-burst is ignored.
- count=0 -> no pal_we, done pulses once, busy never stays high beyond the done cycle. count=512 from base 0x100 -> 512 writes, addresses wrap through 0x0FF.
- Reset mid-burst (async, between accepts with entries in flight) -> pal_we=0 and all outputs at reset values immediately, no later writes, no done.
- Round-trip: 1000 random RGB888 values through the loader, then through a model of the decoder -> {r,g,b} 7-bit values recovered exactly. With PALETTE_LOADER_CHECKSUM_EN, checksum matches the model.
